// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and types, used by uart_rx and the transmitter.
// Holds the parity-mode codes, the receiver FSM state enum and the error-flag bundle.
package uart_pkg;

  // Parity modes selected by the CHECK parameter
  localparam int CHECK_NONE = 0;
  localparam int CHECK_ODD  = 1;
  localparam int CHECK_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_CHECK     = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  typedef struct packed {
    logic perr;
    logic ferr;
  } uart_flags_t;

  // xr is the XOR of the data bits and the parity bit.
  function automatic logic parity_err(
    input int   mode,
    input logic xr
  );
    logic err;
    err = 1'b0;
    if (mode == CHECK_ODD)
      err = ~xr;
    else if (mode == CHECK_EVEN)
      err = xr;
    return err;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for the idle-high serial line.
// Ports: i_clk, i_rst (sync, active-high), i_d async in, o_q synced out.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Both flops reset to 1 so the line looks idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: bit-clocked UART receiver, one serial bit per i_clk, no oversampling.
// Params DATA_WIDTH (5..8), CHECK (0 none/1 odd/2 even), STOP_WIDTH (1..2).
// Ports: i_clk, i_rst (sync, active-high), i_rx serial in (idle high),
//   o_rx_data/o_rx_valid/i_rx_ready word handshake, o_parity_err and
//   o_frame_err flags of the presented word, o_overrun drop pulse.
// Define UART_RX_SYNC_EN to pass i_rx through uart_sync2 (+2 cycles latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHECK      = 1,
  parameter int STOP_WIDTH = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overrun
);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_DATA      = ST_DATA;
  localparam logic [2:0] S_CHECK     = ST_CHECK;
  localparam logic [2:0] S_STOP      = ST_STOP;
  localparam logic [2:0] S_WAIT_HIGH = ST_WAIT_HIGH;

  localparam logic [2:0] DW_LAST = 3'(DATA_WIDTH - 1);
  localparam logic [2:0] SW_LAST = 3'(STOP_WIDTH - 1);
  localparam bit         HAS_CHK = (CHECK != CHECK_NONE);

  logic                  rx_s;
  logic [2:0]            state;
  logic [2:0]            cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err;
  logic                  frm_err;
  logic                  stop_bad;

  logic                  done;
  logic [DATA_WIDTH-1:0] done_data;
  uart_flags_t           done_flags;
  uart_flags_t           out_flags;
  logic                  hs;

`ifdef UART_RX_SYNC_EN
  uart_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );
`else
  assign rx_s = i_rx;
`endif

  // Frame error so far, including the stop bit sampled this cycle
  assign stop_bad = frm_err | ~rx_s;

  // Frame FSM. The finished frame is staged in done_* on the edge that
  // samples the last stop bit; the output stage picks it up one edge later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      done       <= 1'b0;
      done_data  <= '0;
      done_flags <= '0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (!rx_s) begin
            state   <= S_DATA;
            cnt     <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        (state == S_DATA): begin
          shreg <= {shreg[DATA_WIDTH-2:0], rx_s};
          if (cnt == DW_LAST) begin
            cnt   <= '0;
            state <= HAS_CHK ? S_CHECK : S_STOP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        (state == S_CHECK): begin
          par_err <= parity_err(CHECK, (^shreg) ^ rx_s);
          cnt     <= '0;
          state   <= S_STOP;
        end
        (state == S_STOP): begin
          if (cnt == SW_LAST) begin
            done            <= 1'b1;
            done_data       <= shreg;
            done_flags.perr <= par_err;
            done_flags.ferr <= stop_bad;
            cnt             <= '0;
            state           <= stop_bad ? S_WAIT_HIGH : S_IDLE;
          end else begin
            frm_err <= stop_bad;
            cnt     <= cnt + 3'd1;
          end
        end
        (state == S_WAIT_HIGH): begin
          if (rx_s)
            state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign hs = o_rx_valid & i_rx_ready;

  // Output holding register: a new word loads only when the slot is free
  // or being emptied this cycle; otherwise it is dropped with a pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_data  <= '0;
      out_flags  <= '0;
      o_rx_valid <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done) begin
        if (!o_rx_valid || hs) begin
          o_rx_data  <= done_data;
          out_flags  <= done_flags;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (hs) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

  assign o_parity_err = out_flags.perr;
  assign o_frame_err  = out_flags.ferr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx (8 data, odd, 1 stop).
// A serializer pushes expected words; a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int DW   = 8;
  localparam int CHKP = 1;
  localparam int SW   = 1;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = DW + ((CHKP != 0) ? 1 : 0) + SW + 1 + 2;
`else
  localparam int LAT = DW + ((CHKP != 0) ? 1 : 0) + SW + 1;
`endif

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
    bit         drop;
    int         t;
  } exp_t;

  logic          clk;
  logic          i_rst;
  logic          i_rx;
  logic [DW-1:0] o_rx_data;
  logic          o_rx_valid;
  logic          i_rx_ready;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_overrun;

  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t q[$];

  uart_rx #(
    .DATA_WIDTH (DW),
    .CHECK      (CHKP),
    .STOP_WIDTH (SW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .i_rx_ready   (i_rx_ready),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic bit_out(input logic b);
    @(posedge clk);
    #1;
    i_rx = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bit_out(1'b1);
  endtask

  // Serialize one frame; the expected result is derived from counting ones.
  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, input bit drop);
    exp_t e;
    bit   pb;
    @(posedge clk);
    #1;
    pb     = ($countones(d) % 2) == 0;
    e.data = d;
    e.perr = bad_par;
    e.ferr = bad_stop;
    e.drop = drop;
    e.t    = cyc + 1 + LAT;
    q.push_back(e);
    i_rx = 1'b0;
    for (int i = DW - 1; i >= 0; i--) bit_out(d[i]);
    bit_out(bad_par ? ~pb : pb);
    for (int s = 0; s < SW; s++) bit_out((bad_stop && s == 0) ? 1'b0 : 1'b1);
  endtask

  // Monitor: scores every newly presented word and every overrun pulse.
  initial begin : monitor
    bit         prev_valid;
    bit         prev_hs;
    bit         new_w;
    logic [7:0] held_d;
    bit         held_p;
    bit         held_f;
    exp_t       e;
    prev_valid = 0;
    prev_hs    = 0;
    held_d     = '0;
    held_p     = 0;
    held_f     = 0;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        new_w = o_rx_valid && (!prev_valid || prev_hs);
        if (o_overrun) begin
          if (q.size() == 0) begin
            chk("overrun_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("overrun_expected", 1, 32'(e.drop));
            chk("overrun_time", cyc, e.t);
          end
        end
        if (new_w) begin
          if (q.size() == 0) begin
            chk("word_unexpected", 32'(o_rx_data), 32'hFFFF);
          end else begin
            e = q.pop_front();
            chk("presented", 1, 32'(!e.drop));
            chk("data", 32'(o_rx_data), 32'(e.data));
            chk("parity_err", 32'(o_parity_err), 32'(e.perr));
            chk("frame_err", 32'(o_frame_err), 32'(e.ferr));
            chk("latency", cyc, e.t);
          end
          held_d = o_rx_data;
          held_p = o_parity_err;
          held_f = o_frame_err;
        end else if (o_rx_valid) begin
          chk("hold_data", 32'(o_rx_data), 32'(held_d));
          chk("hold_flags", {o_parity_err, o_frame_err}, {held_p, held_f});
        end
      end
      prev_valid = o_rx_valid;
      prev_hs    = o_rx_valid && i_rx_ready;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int gap;
    bit bp;
    bit bs;
    n_vec      = 0;
    n_err      = 0;
    i_rst      = 1'b1;
    i_rx       = 1'b1;
    i_rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(o_rx_data), 0);
    chk("rst_valid", 32'(o_rx_valid), 0);
    chk("rst_perr", 32'(o_parity_err), 0);
    chk("rst_ferr", 32'(o_frame_err), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    idle(4);

    // Clean frame, corrupted parity, stop error with line stuck low
    send_frame(8'hA5, 0, 0, 0);
    idle(2);
    send_frame(8'h3C, 1, 0, 0);
    idle(2);
    send_frame(8'h81, 0, 1, 0);
    for (int i = 0; i < 5; i++) bit_out(1'b0);
    idle(3);

    // Random frames with random errors and gaps
    for (int k = 0; k < 20; k++) begin
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 5) == 0);
      gap = bs ? $urandom_range(2, 4) : $urandom_range(0, 3);
      send_frame(8'($urandom), bp, bs, 0);
      idle(gap);
    end

    // Ten frames back to back
    for (int k = 0; k < 10; k++) send_frame(8'($urandom), 0, 0, 0);
    idle(3);

    // Stalled consumer: second word is dropped, first is kept
    @(posedge clk);
    #1;
    i_rx_ready = 1'b0;
    send_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 0, 0, 1);
    idle(2);
    @(negedge clk);
    chk("kept_11", 32'(o_rx_data), 32'h11);
    chk("kept_valid", 32'(o_rx_valid), 1);

    // Handshake on the same edge a new frame completes
    fork
      send_frame(8'h5A, 0, 0, 0);
      begin
        repeat (LAT + 1) @(posedge clk);
        #1;
        i_rx_ready = 1'b1;
      end
    join
    idle(3);

    // Reset mid-frame, with an unconsumed word held
    @(posedge clk);
    #1;
    i_rx_ready = 1'b0;
    send_frame(8'h77, 0, 0, 0);
    idle(2);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b1);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    i_rx  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(o_rx_valid), 0);
    chk("midrst_data", 32'(o_rx_data), 0);
    chk("midrst_flags", {o_parity_err, o_frame_err, o_overrun}, 0);
    @(posedge clk);
    #1;
    i_rst      = 1'b0;
    i_rx_ready = 1'b1;
    idle(2);
    send_frame(8'h0F, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL accept parameter DATA_WIDTH, default 8, giving the number of data bits per frame (legal range 5..8).
REQ-002 The module SHALL accept parameter CHECK, default 1, selecting the parity mode: 0 none, 1 odd, 2 even.
REQ-003 The module SHALL accept parameter STOP_WIDTH, default 1, giving the number of stop bits (1 or 2).
REQ-004 The module SHALL have port i_clk, input, width 1: the bit clock, one serial bit per cycle.
REQ-005 The module SHALL have port i_rst, input, width 1: synchronous, active-high reset.
REQ-006 The module SHALL have port i_rx, input, width 1: the serial line, idle high.
REQ-007 The module SHALL have port o_rx_data, output, width DATA_WIDTH: the received word.
REQ-008 The module SHALL have port o_rx_valid, output, width 1: o_rx_data holds an unconsumed word.
REQ-009 The module SHALL have port i_rx_ready, input, width 1: the consumer accepts the word.
REQ-010 The module SHALL have port o_parity_err, output, width 1: the presented word failed the parity check.
REQ-011 The module SHALL have port o_frame_err, output, width 1: at least one stop bit of the presented word was sampled 0.
REQ-012 The module SHALL have port o_overrun, output, width 1: one-cycle pulse when a completed frame is dropped.

Function
REQ-013 The receiver SHALL sample i_rx once per i_clk rising edge (the "sampled line"); there is no oversampling.
REQ-014 The FSM SHALL use states IDLE, DATA, CHECK, STOP and WAIT_HIGH.
REQ-015 In IDLE, a sampled 0 SHALL be taken as the start bit and the FSM SHALL move to DATA with the bit counter cleared.
REQ-016 DATA SHALL capture DATA_WIDTH consecutive samples MSB first, shifting each into the LSB; it SHALL then go to CHECK if CHECK>0, else to STOP.
REQ-017 CHECK SHALL sample one bit: odd mode errs if XOR(data, bit)=0, even mode errs if XOR(data, bit)=1; the FSM SHALL then go to STOP.
REQ-018 STOP SHALL sample STOP_WIDTH bits; frame error is set if any of them is 0.
REQ-019 On the edge that samples the last stop bit, the word and its error flags SHALL be registered and o_rx_valid SHALL rise on the following cycle.
REQ-020 Latency: o_rx_valid SHALL be high DATA_WIDTH+(CHECK>0)+STOP_WIDTH+1 cycles after the edge that sampled the start bit.
REQ-021 After a frame with no frame error the FSM SHALL return to IDLE; after a frame error it SHALL go to WAIT_HIGH and remain there until a sampled 1, then return to IDLE.
REQ-022 o_rx_data, o_parity_err and o_frame_err SHALL hold stable while o_rx_valid=1 and SHALL change only on a completed frame.
REQ-023 A handshake (o_rx_valid & i_rx_ready) SHALL clear o_rx_valid on the next cycle.
REQ-024 If a frame completes in the same cycle as a handshake, the new word SHALL be loaded and o_rx_valid SHALL stay 1.
REQ-025 If a frame completes while o_rx_valid=1 and there is no handshake, the new word SHALL be discarded, the old word kept, and o_overrun pulsed for one cycle.
REQ-026 Back-to-back frames, with the next start bit immediately after the last stop bit, SHALL be received without loss.

Reset
REQ-027 On i_rst the FSM SHALL go to IDLE and the counters and shift register SHALL clear.
REQ-028 On i_rst, o_rx_data=0, o_rx_valid=0, o_parity_err=0, o_frame_err=0 and o_overrun=0.
REQ-029 A reset mid-frame SHALL abandon the frame with no output.

Configuration
REQ-030 With UART_RX_SYNC_EN defined, i_rx SHALL pass through a two-flop synchronizer (reset to 1) before sampling, and all latencies SHALL grow by 2 cycles.
REQ-031 Without UART_RX_SYNC_EN, i_rx SHALL be sampled directly.

Structure
REQ-032 A shared package uart_pkg SHALL hold the parity-mode constants (CHECK_NONE=0, CHECK_ODD=1, CHECK_EVEN=2) and the FSM state enum, and SHALL be used by both uart_rx and the transmitter.
REQ-033 The synchronizer SHALL be a sub-module uart_sync2; no other sub-modules.

Verification
REQ-034 Loopback from the transmitter (CHECK=1), sending 0xA5 -> o_rx_data=0xA5, parity and frame errors 0, valid 11 cycles after the start-bit sample.
REQ-035 Drive 0x3C with the odd parity bit inverted -> o_rx_data=0x3C, o_parity_err=1, o_frame_err=0.
REQ-036 Drive 0x81 with a stop bit of 0 and the line held low for 5 cycles -> o_frame_err=1, no new frame until the line returns high.
REQ-037 Hold i_rx_ready=0 and send 0x11 then 0x22 -> o_rx_data stays 0x11, and o_overrun pulses once on completion of 0x22.
REQ-038 Assert i_rst during data bit 4 of 0xF0, then send 0x0F -> only 0x0F is delivered.
REQ-039 Send ten back-to-back frames with i_rx_ready=1 -> all ten received in order, with o_overrun never asserted.
